// File: rtl/arrmul_mac_acc.sv
// Multiply-accumulate stage around an external 4x4 array multiplier: registers operand pairs,
// sums LEN products into ACC_W bits. Define ARRMUL_MAC_SATURATE_EN to clamp instead of wrap.
//
// state | meaning
// ACC   | accepting operand pairs, products accumulate back to back
// FLUSH | last product in flight, accumulated on this edge
// DONE  | result presented downstream until out_fire
module arrmul_mac_acc #(
    parameter int LEN   = 4,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic [3:0]       mul_a,
    output logic [3:0]       mul_b,
    input  logic [7:0]       mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     count;
    logic              p_vld;
    logic [ACC_W-1:0]  acc;
    logic              ovf;
    logic              in_fire, out_fire;
    logic [ACC_W:0]    sum_ext;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign sum_ext  = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, mul_p};
    assign out_sum  = acc;
    assign out_ovf  = ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // in_valid used directly in ACC to keep in_ready off the in_fire path
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && count == LAST) state_nxt = FLUSH;
            end
            FLUSH: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ACC;
            end
            default: state_nxt = ACC;
        endcase
        if (clr) state_nxt = ACC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a <= 4'd0;
            mul_b <= 4'd0;
            p_vld <= 1'b0;
            count <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            p_vld <= 1'b0;
            count <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            p_vld <= in_fire;
            if (in_fire) begin
                mul_a <= in_a;
                mul_b <= in_b;
                count <= count + CW'(1);
            end
            if (out_fire) begin
                acc   <= '0;
                ovf   <= 1'b0;
                count <= '0;
            end else if (p_vld) begin
                if (sum_ext[ACC_W]) ovf <= 1'b1;
`ifdef ARRMUL_MAC_SATURATE_EN
                acc <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
`else
                acc <= sum_ext[ACC_W-1:0];
`endif
            end
        end
    end

endmodule

// File: tb/tb_arrmul_mac_acc.sv
// Bench for arrmul_mac_acc: default LEN=4/ACC_W=12 instance plus a LEN=2/ACC_W=8 overflow instance,
// each with a behavioural array multiplier on mul_a/mul_b.
module tb_arrmul_mac_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic [3:0]  in_a, in_b, mul_a, mul_b;
    logic [7:0]  mul_p;
    logic [11:0] out_sum;

    logic        clr8, in_valid8, in_ready8, out_valid8, out_ready8, out_ovf8;
    logic [3:0]  in_a8, in_b8, mul_a8, mul_b8;
    logic [7:0]  mul_p8, out_sum8;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign mul_p  = {4'd0, mul_a}  * {4'd0, mul_b};
    assign mul_p8 = {4'd0, mul_a8} * {4'd0, mul_b8};

    arrmul_mac_acc #(.LEN(4), .ACC_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
    );

    arrmul_mac_acc #(.LEN(2), .ACC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .clr(clr8),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_a(in_a8), .in_b(in_b8),
        .mul_a(mul_a8), .mul_b(mul_b8), .mul_p(mul_p8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_sum(out_sum8), .out_ovf(out_ovf8)
    );

    typedef struct {
        logic [15:0] av;
        logic [15:0] bv;
        int          gap;
        int          stall;
        logic [11:0] sum;
        logic        ovf;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fire(input logic [3:0] a, input logic [3:0] b);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        step();
        in_valid = 1'b0;
    endtask

    // Expected batch result from plain arithmetic on the products
    function automatic void model12(input logic [15:0] av, input logic [15:0] bv,
                                    output logic [11:0] s, output logic o);
        int total = 0;
        for (int i = 0; i < 4; i++) total += int'(av[4*i +: 4]) * int'(bv[4*i +: 4]);
        s = 12'(total % 4096);
        o = (total >= 4096);
    endfunction

    task automatic run_batch(input logic [15:0] av, input logic [15:0] bv, input int gap,
                             input int stall, input logic [11:0] es, input logic eo,
                             input string nm);
        logic [3:0] la, lb;
        out_ready = (stall == 0);
        chk({nm, " in_ready_start"}, in_ready, 1);
        la = 4'd0;
        lb = 4'd0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                step();
                if (i > 0) begin
                    chk({nm, " mul_a_hold"}, mul_a, la);
                    chk({nm, " mul_b_hold"}, mul_b, lb);
                end
            end
            la = av[4*i +: 4];
            lb = bv[4*i +: 4];
            in_valid = 1'b1;
            in_a = la;
            in_b = lb;
            step();
            chk({nm, " mul_a"}, mul_a, la);
            chk({nm, " mul_b"}, mul_b, lb);
        end
        in_a = ~la;
        in_b = ~lb;
        chk({nm, " flush_out_valid"}, out_valid, 0);
        chk({nm, " flush_in_ready"}, in_ready, 0);
        step();
        chk({nm, " out_valid"}, out_valid, 1);
        chk({nm, " done_in_ready"}, in_ready, 0);
        chk({nm, " out_sum"}, out_sum, es);
        chk({nm, " out_ovf"}, out_ovf, eo);
        for (int s = 0; s < stall; s++) begin
            step();
            chk({nm, " stall_valid"}, out_valid, 1);
            chk({nm, " stall_sum"}, out_sum, es);
            chk({nm, " stall_ovf"}, out_ovf, eo);
            chk({nm, " stall_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk({nm, " back_in_ready"}, in_ready, 1);
        chk({nm, " back_out_valid"}, out_valid, 0);
        chk({nm, " ignored_in_valid"}, mul_a, la);
    endtask

    task automatic batch8(input logic [3:0] a0, input logic [3:0] b0,
                          input logic [3:0] a1, input logic [3:0] b1, input string nm);
        int total;
        logic [7:0] es;
        logic eo;
        total = int'(a0) * int'(b0) + int'(a1) * int'(b1);
        eo = (total > 255);
`ifdef ARRMUL_MAC_SATURATE_EN
        es = eo ? 8'hFF : 8'(total);
`else
        es = 8'(total % 256);
`endif
        out_ready8 = 1'b1;
        in_valid8 = 1'b1;
        in_a8 = a0;
        in_b8 = b0;
        step();
        in_a8 = a1;
        in_b8 = b1;
        step();
        in_valid8 = 1'b0;
        chk({nm, " flush_in_ready"}, in_ready8, 0);
        step();
        chk({nm, " out_valid"}, out_valid8, 1);
        chk({nm, " out_sum"}, out_sum8, es);
        chk({nm, " out_ovf"}, out_ovf8, eo);
        step();
        chk({nm, " back_in_ready"}, in_ready8, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rav, rbv;
        logic [11:0] rs;
        logic        ro;

        tbl[0] = '{16'h70F3, 16'h29F5, 0, 0, 12'd254, 1'b0};
        tbl[1] = '{16'hFFFF, 16'hFFFF, 0, 5, 12'd900, 1'b0};
        tbl[2] = '{16'h1111, 16'h1111, 0, 0, 12'd4,   1'b0};
        tbl[3] = '{16'h2222, 16'h2222, 2, 0, 12'd16,  1'b0};
        tbl[4] = '{16'h1111, 16'h2222, 1, 2, 12'd8,   1'b0};

        rst_n = 1'b1;
        clr = 1'b0; in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0; out_ready = 1'b1;
        clr8 = 1'b0; in_valid8 = 1'b0; in_a8 = 4'd0; in_b8 = 4'd0; out_ready8 = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_sum", out_sum, 0);
        chk("rst out_ovf", out_ovf, 0);
        chk("rst mul_a", mul_a, 0);
        chk("rst mul_b", mul_b, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++)
            run_batch(tbl[i].av, tbl[i].bv, tbl[i].gap, tbl[i].stall, tbl[i].sum, tbl[i].ovf,
                      $sformatf("tbl%0d", i));

        // clr mid-batch, with a same-cycle in_valid that must be discarded
        fire(4'd15, 4'd15);
        fire(4'd15, 4'd15);
        clr = 1'b1;
        in_valid = 1'b1;
        in_a = 4'd9;
        in_b = 4'd9;
        step();
        clr = 1'b0;
        in_valid = 1'b0;
        chk("clr in_ready", in_ready, 1);
        chk("clr out_sum", out_sum, 0);
        run_batch(16'h1111, 16'h2222, 0, 0, 12'd8, 1'b0, "after_clr");

        // clr while the result is being presented
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) fire(4'd1, 4'd1);
        step();
        chk("clr_done out_valid_pre", out_valid, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        out_ready = 1'b1;
        chk("clr_done out_valid", out_valid, 0);
        chk("clr_done in_ready", in_ready, 1);
        chk("clr_done out_sum", out_sum, 0);
        run_batch(16'h3333, 16'h1111, 0, 0, 12'd12, 1'b0, "after_clr_done");

        // asynchronous reset while in FLUSH
        for (int i = 0; i < 4; i++) fire(4'd3, 4'd3);
        chk("pre_rst flush in_ready", in_ready, 0);
        chk("pre_rst acc", out_sum, 27);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst in_ready", in_ready, 1);
        chk("async_rst out_valid", out_valid, 0);
        chk("async_rst out_sum", out_sum, 0);
        chk("async_rst mul_a", mul_a, 0);
        #2 rst_n = 1'b1;
        step();
        chk("post_rst out_valid", out_valid, 0);
        run_batch(16'h4444, 16'h4444, 0, 0, 12'd64, 1'b0, "after_rst");

        for (int r = 0; r < 16; r++) begin
            rav = 16'($urandom);
            rbv = 16'($urandom);
            model12(rav, rbv, rs, ro);
            run_batch(rav, rbv, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rs, ro,
                      $sformatf("rand%0d", r));
        end

        batch8(4'd15, 4'd15, 4'd15, 4'd15, "ovf8_a");
        batch8(4'd10, 4'd10, 4'd12, 4'd12, "ovf8_b");
        batch8(4'd15, 4'd15, 4'd2, 4'd3, "ovf8_c");
        batch8(4'd15, 4'd15, 4'd15, 4'd15, "ovf8_d");
        batch8(4'd1, 4'd1, 4'd2, 4'd2, "ovf8_e");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
